// File: rtl/bloom_rule_writer.sv
// Bloom filter programming path: hashes accepted rule tuples with the lookup-path
// mix and issues single-bit set writes; also sweeps the whole filter clear on request.
module bloom_rule_writer #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rule_valid,
  output logic             rule_ready,
  input  logic [71:0]      rule_ip_protocol,
  input  logic [15:0]      rule_src_port,
  input  logic [15:0]      rule_dst_port,
  input  logic             clear_req,
  output logic             bf_wr_en,
  output logic [IDX_W-1:0] bf_wr_idx,
  output logic             bf_wr_val,
  output logic             ins_done,
  output logic             clear_done,
  output logic             busy,
  output logic [CNT_W-1:0] rule_count
);

  typedef enum logic [1:0] {IDLE, MIX, WRITE, CLEAR} state_t;

  state_t       state;
  logic         clear_pend;
  logic [31:0]  a, b, c;
  logic [2:0]   step;
  logic [IDX_W:0] sweep;
  logic [31:0]  hash;
  logic         unused_bits;

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  assign hash        = (c ^ b) - rol(b, 24);
  assign unused_bits = ^{rule_ip_protocol[71:32], rule_dst_port[15:8], hash[31:IDX_W]};
  assign rule_ready  = !reset && (state == IDLE) && !clear_req && !clear_pend;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clear_pend <= 1'b0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      step       <= '0;
      sweep      <= '0;
      bf_wr_en   <= 1'b0;
      bf_wr_idx  <= '0;
      bf_wr_val  <= 1'b0;
      ins_done   <= 1'b0;
      clear_done <= 1'b0;
      rule_count <= '0;
    end else begin
      bf_wr_en   <= 1'b0;
      bf_wr_idx  <= '0;
      bf_wr_val  <= 1'b0;
      ins_done   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          // Outputs are registered, so index 0 is issued on the way into CLEAR.
          if (clear_req || clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            bf_wr_en   <= 1'b1;
            sweep      <= (IDX_W+1)'(1);
          end else if (rule_valid) begin
            a     <= 32'hdeadbef8 + rule_ip_protocol[31:0];
            b     <= 32'hdeadbef1 + {16'h0000, rule_src_port};
            c     <= 32'hdeadbef8 + {24'h000000, rule_dst_port[7:0]};
            step  <= '0;
            state <= MIX;
          end
        end
        MIX: begin
          if (clear_req) clear_pend <= 1'b1;
          step <= step + 3'd1;
          // Step 0 is the seed-settle cycle that fixes the write at 8 cycles after acceptance.
          case (step)
            3'd1: c <= (c ^ b) - rol(b, 14);
            3'd2: a <= (a ^ c) - rol(c, 11);
            3'd3: b <= (b ^ a) - rol(a, 25);
            3'd4: a <= (a ^ c) - rol(c, 4);
            3'd5: b <= (b ^ a) - rol(a, 14);
            3'd6: begin
              bf_wr_en  <= 1'b1;
              bf_wr_val <= 1'b1;
              bf_wr_idx <= hash[IDX_W-1:0];
              ins_done  <= 1'b1;
              if (rule_count != '1) rule_count <= rule_count + CNT_W'(1);
              state     <= WRITE;
            end
            default: ;
          endcase
        end
        WRITE: begin
          if (clear_req || clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            bf_wr_en   <= 1'b1;
            sweep      <= (IDX_W+1)'(1);
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (sweep[IDX_W]) begin
            rule_count <= '0;
            clear_done <= 1'b1;
            state      <= IDLE;
          end else begin
            bf_wr_en  <= 1'b1;
            bf_wr_idx <= sweep[IDX_W-1:0];
            sweep     <= sweep + (IDX_W+1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_rule_writer.sv
// Randomized bench for bloom_rule_writer against a cycle-scheduled reference model.
module tb_bloom_rule_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rule_valid;
  logic        rule_ready;
  logic [71:0] rule_ip_protocol;
  logic [15:0] rule_src_port;
  logic [15:0] rule_dst_port;
  logic        clear_req;
  logic        bf_wr_en;
  logic [9:0]  bf_wr_idx;
  logic        bf_wr_val;
  logic        ins_done;
  logic        clear_done;
  logic        busy;
  logic [15:0] rule_count;

  bloom_rule_writer #(.IDX_W(10), .CNT_W(16)) dut (
    .clk(clk), .reset(rst), .rule_valid(rule_valid), .rule_ready(rule_ready),
    .rule_ip_protocol(rule_ip_protocol), .rule_src_port(rule_src_port),
    .rule_dst_port(rule_dst_port), .clear_req(clear_req), .bf_wr_en(bf_wr_en),
    .bf_wr_idx(bf_wr_idx), .bf_wr_val(bf_wr_val), .ins_done(ins_done),
    .clear_done(clear_done), .busy(busy), .rule_count(rule_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: expected events keyed by absolute cycle number.
  logic [9:0] exp_idx [int];
  bit         exp_val [int];
  bit         exp_ins [int];
  bit         exp_done [int];
  int         cnt_at [int];
  int         next_idle = 0;
  int         rule_w = -1;
  bit         clr_sched = 0;
  int         fut = 0;
  int         mcnt = 0;

  function automatic logic [31:0] rol(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] mix(input logic [71:0] ip, input logic [15:0] sp, input logic [15:0] dp);
    logic [31:0] ma, mb, mc;
    ma = 32'hdeadbef8 + ip[31:0];
    mb = 32'hdeadbef1 + {16'h0, sp};
    mc = 32'hdeadbef8 + {24'h0, dp[7:0]};
    mc = (mc ^ mb) - rol(mb, 14);
    ma = (ma ^ mc) - rol(mc, 11);
    mb = (mb ^ ma) - rol(ma, 25);
    ma = (ma ^ mc) - rol(mc, 4);
    mb = (mb ^ ma) - rol(ma, 14);
    return (mc ^ mb) - rol(mb, 24);
  endfunction

  task automatic sched_clear(input int s);
    for (int i = 0; i < 1024; i++) begin
      exp_idx[s + 1 + i] = 10'(i);
      exp_val[s + 1 + i] = 1'b0;
    end
    exp_done[s + 1025] = 1'b1;
    cnt_at[s + 1025]   = 0;
    fut       = 0;
    next_idle = s + 1025;
    clr_sched = 1'b1;
  endtask

  task automatic step(input bit v, input logic [71:0] ip, input logic [15:0] sp,
                      input logic [15:0] dp, input bit clr, output bit acc);
    bit er;
    int w;
    rule_valid = v; rule_ip_protocol = ip; rule_src_port = sp; rule_dst_port = dp;
    clear_req = clr;
    er = 1'b0; acc = 1'b0;
    if (cyc >= next_idle) begin
      if (clr) sched_clear(cyc);
      else begin
        er = 1'b1;
        if (v) begin
          w = cyc + 8;
          exp_idx[w] = mix(ip, sp, dp) & 32'h3ff;
          exp_val[w] = 1'b1;
          exp_ins[w] = 1'b1;
          fut = (fut == 65535) ? fut : fut + 1;
          cnt_at[w] = fut;
          next_idle = cyc + 9;
          rule_w = w;
          clr_sched = 1'b0;
          acc = 1'b1;
        end
      end
    end else if (cyc <= rule_w && clr && !clr_sched) begin
      sched_clear(rule_w);
    end
    @(negedge clk);
    chk("rule_ready", rule_ready, er);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, acc);
  endtask

  task automatic drain();
    int guard = 0;
    while (cyc < next_idle + 2 && guard < 3000) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rule_valid = 1'b0; clear_req = 1'b0;
    exp_idx.delete(); exp_val.delete(); exp_ins.delete(); exp_done.delete(); cnt_at.delete();
    fut = 0; mcnt = 0; rule_w = -1; clr_sched = 1'b0;
    #1;
    chk("rst_wr_en", bf_wr_en, 0);
    chk("rst_wr_idx", bf_wr_idx, 0);
    chk("rst_wr_val", bf_wr_val, 0);
    chk("rst_ins_done", ins_done, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", rule_count, 0);
    chk("rst_ready", rule_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    next_idle = cyc;
    #1;
    chk("post_rst_ready", rule_ready, 1);
    chk("post_rst_count", rule_count, 0);
  endtask

  always @(negedge clk) begin
    bit ew;
    if (!rst) begin
      if (cnt_at.exists(cyc)) mcnt = cnt_at[cyc];
      ew = exp_val.exists(cyc);
      if (bf_wr_en || ew) begin
        chk("wr_en", bf_wr_en, ew);
        if (bf_wr_en && ew) begin
          chk("wr_idx", bf_wr_idx, exp_idx[cyc]);
          chk("wr_val", bf_wr_val, exp_val[cyc]);
        end
        chk("rule_count", rule_count, mcnt);
      end else if (bf_wr_idx != '0 || bf_wr_val) begin
        chk("idle_drive", {bf_wr_idx, bf_wr_val}, 0);
      end
      if (ins_done || exp_ins.exists(cyc)) chk("ins_done", ins_done, exp_ins.exists(cyc));
      if (clear_done || exp_done.exists(cyc)) begin
        chk("clear_done", clear_done, exp_done.exists(cyc));
        chk("rule_count", rule_count, mcnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k, guard, n_clr;
    logic [71:0] ip;
    logic [15:0] sp, dp;
    rst = 1'b1; rule_valid = 1'b0; clear_req = 1'b0;
    rule_ip_protocol = '0; rule_src_port = '0; rule_dst_port = '0;
    @(posedge clk); #1;
    do_reset();
    idle(2);

    // Single directed rule.
    step(1'b1, 72'h0A000001, 16'h1F90, 16'h0050, 1'b0, acc);
    drain();

    // Four back-to-back rules with valid held.
    k = 0; guard = 0;
    while (k < 4 && guard < 60) begin
      step(1'b1, {8'(k), $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    chk("b2b_accepted", k, 4);
    drain();

    // Masking: dst upper byte and ip[71:32] must not matter.
    ip = {8'h00, 32'h00000000, 32'hC0A80101};
    step(1'b1, ip, 16'h0400, 16'h1234, 1'b0, acc);
    drain();
    ip[71:32] = 40'hA5_5A5A_A5A5;
    step(1'b1, ip, 16'h0400, 16'hFF34, 1'b0, acc);
    drain();

    // Clear request during MIX cycle 3.
    step(1'b1, {8'h11, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0, acc);
    idle(2);
    step(1'b0, '0, '0, '0, 1'b1, acc);
    drain();

    // Clear and rule requested together in IDLE.
    ip = {8'h22, $urandom, $urandom}; sp = 16'($urandom); dp = 16'($urandom);
    step(1'b1, ip, sp, dp, 1'b1, acc);
    chk("clr_priority", acc, 0);
    guard = 0; acc = 1'b0;
    while (!acc && guard < 1100) begin
      step(1'b1, ip, sp, dp, 1'b0, acc);
      guard++;
    end
    chk("accept_after_clear", acc, 1);
    drain();

    // Randomized traffic with occasional clears.
    n_clr = 0;
    for (int i = 0; i < 300; i++) begin
      bit c;
      c = (n_clr < 2) && ($urandom_range(0, 99) == 0);
      if (c) n_clr++;
      step(1'($urandom_range(0, 1)), {8'($urandom), $urandom, $urandom},
           16'($urandom), 16'($urandom), c, acc);
    end
    drain();

    // Reset mid-MIX.
    step(1'b1, {8'h33, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0, acc);
    idle(3);
    do_reset();
    idle(12);

    // Reset mid-CLEAR, in the cycle index 500 is being written.
    step(1'b0, '0, '0, '0, 1'b1, acc);
    idle(500);
    do_reset();
    idle(12);
    step(1'b1, {8'h44, $urandom, $urandom}, 16'($urandom), 16'($urandom), 1'b0, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
